mac_array_seq: RTL and testbench

Job sequencer for the WS/OS reconfigurable MAC array. It takes a start command with a dataflow mode and reduction length. From those it drives the array's `os_en` and per-row skewed 2-bit instructions, gates the activation and weight feeders, and inserts the flush and zero-feed cycles the tiles need. In OS mode it also walks the accumulated-result readout row by row. It sits between the top-level command interface and the array/feeder/readout logic.

---
 rtl/mac_array_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_mac_array_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// mac_array_seq - job sequencer for the WS/OS reconfigurable MAC array.
//
// Accepts a start command carrying a dataflow mode and a reduction length,
// then drives the array dataflow select, the per-row skewed 2-bit
// instructions, the feeder pop/zero controls and, in OS mode, the row-by-row
// result readout.
//
// Parameters:
//   row  array rows (>= 2); row r instruction lags row 0 by r cycles
//   col  array columns; sets WS load length and settle length
//   kbw  width of k_len
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   start        job request, sampled only while idle
//   mode         0 = WS, 1 = OS; latched with start
//   k_len        reduction length K; latched with start
//   os_en        array dataflow select
//   inst_w       row r instruction in bits [2r+1:2r] (bit1 execute, bit0 load)
//   act_rd       activation/kernel feeder pop, row-0 timing
//   wgt_rd       north weight feeder pop, row-0 timing, OS only
//   feed_zero    feeders drive zero on in_w/in_n, row-0 timing
//   rd_valid     OS readout strobe
//   rd_row       row whose results are valid while rd_valid is high
//   busy         high whenever a job is in progress
//   done         one-cycle completion pulse
//   err          one-cycle pulse when start arrives with k_len == 0
//   perf_cycles  cumulative busy-cycle count (see macro below)
//
// Build option:
//   MAC_SEQ_PERF_CNT_EN  when defined, perf_cycles counts busy cycles across
//                        jobs (wraps at 2^32, cleared only by reset); when not
//                        defined, perf_cycles is tied to 0.
//
// State table:
//   IDLE   | waiting for start; all outputs low
//   FLUSH  | one zero-feed cycle to clear tile psum / OS-ready state
//   LOAD   | WS kernel load, col cycles, row-0 inst = 01
//   EXEC   | execute, K (WS) or K+1 (OS) cycles, row-0 inst = 10
//   SETTLE | drain skew wave / psum pipe, row-1 (OS) or row+col-1 (WS) cycles
//   READ   | OS readout, row cycles, rd_row counts 0..row-1
//   DONE   | one-cycle done pulse

module mac_array_seq #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int kbw = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [kbw-1:0]          k_len,
  output logic                    os_en,
  output logic [2*row-1:0]        inst_w,
  output logic                    act_rd,
  output logic                    wgt_rd,
  output logic                    feed_zero,
  output logic                    rd_valid,
  output logic [$clog2(row)-1:0]  rd_row,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             perf_cycles
);

  localparam int RW = $clog2(row);
  // Must hold K (OS exec reload) and row+col-2 (WS settle reload).
  localparam int CW = ((kbw + 1) > $clog2(row + col)) ? (kbw + 1) : $clog2(row + col);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_EXEC,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_val;
  logic                cnt_ld;
  logic                tc;
  logic                accept;
  logic                err_n;
  logic                err_q;
  logic                mode_q;
  logic [kbw-1:0]      k_q;
  logic [1:0]          inst0;
  logic [2*row-3:0]    skew_q;
  logic [CW-1:0]       rd_row_full;

  assign tc = (cnt == '0);

  // Next state, counter reload and row-0 decode.
  always_comb begin
    state_n   = state;
    cnt_ld    = 1'b0;
    cnt_val   = '0;
    accept    = 1'b0;
    err_n     = 1'b0;
    inst0     = 2'b00;
    act_rd    = 1'b0;
    wgt_rd    = 1'b0;
    feed_zero = 1'b0;
    rd_valid  = 1'b0;
    os_en     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            accept  = 1'b1;
            state_n = S_FLUSH;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        feed_zero = 1'b1;
        cnt_ld    = 1'b1;
        if (mode_q) begin
          state_n = S_EXEC;
          cnt_val = CW'(k_q);          // K+1 exec cycles
        end else begin
          state_n = S_LOAD;
          cnt_val = CW'(col - 1);
        end
      end

      S_LOAD: begin
        inst0  = 2'b01;
        act_rd = 1'b1;
        os_en  = mode_q;
        if (tc) begin
          state_n = S_EXEC;
          cnt_ld  = 1'b1;
          cnt_val = CW'(k_q) - CW'(1);
        end
      end

      S_EXEC: begin
        inst0 = 2'b10;
        os_en = mode_q;
        if (!mode_q) begin
          act_rd = 1'b1;
        end else if (!tc) begin
          act_rd = 1'b1;
          wgt_rd = 1'b1;
        end else begin
          // Extra OS cycle: accumulate the last loaded pair with no new product.
          feed_zero = 1'b1;
        end
        if (tc) begin
          state_n = S_SETTLE;
          cnt_ld  = 1'b1;
          cnt_val = mode_q ? CW'(row - 2) : CW'(row + col - 2);
        end
      end

      S_SETTLE: begin
        os_en = mode_q;
        if (tc) begin
          if (mode_q) begin
            state_n = S_READ;
            cnt_ld  = 1'b1;
            cnt_val = CW'(row - 1);
          end else begin
            state_n = S_DONE;
          end
        end
      end

      S_READ: begin
        os_en    = mode_q;
        rd_valid = 1'b1;
        if (tc) state_n = S_DONE;
      end

      S_DONE: begin
        os_en   = mode_q;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      k_q    <= '0;
      err_q  <= 1'b0;
      skew_q <= '0;
    end else begin
      state  <= state_n;
      err_q  <= err_n;
      // Row r+1 takes row r's instruction one cycle later; shifts in every state.
      skew_q <= inst_w[2*row-3:0];
      if (accept) begin
        mode_q <= mode;
        k_q    <= k_len;
      end
      if (cnt_ld) begin
        cnt <= cnt_val;
      end else if (!tc) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign inst_w = {skew_q, inst0};

  // Readout counter runs down from row-1, so the row index is its complement.
  assign rd_row_full = CW'(row - 1) - cnt;
  assign rd_row      = rd_valid ? rd_row_full[RW-1:0] : '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = err_q;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
`timescale 1ns/1ps
module tb_mac_array_seq;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int KBW  = 8;
  localparam int RW   = $clog2(ROW);
  localparam int OBSW = 1 + 2*ROW + 4 + RW + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [KBW-1:0]    k_len;
  logic              os_en;
  logic [2*ROW-1:0]  inst_w;
  logic              act_rd;
  logic              wgt_rd;
  logic              feed_zero;
  logic              rd_valid;
  logic [RW-1:0]     rd_row;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       perf_cycles;

  mac_array_seq #(.row(ROW), .col(COL), .kbw(KBW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .k_len(k_len),
    .os_en(os_en), .inst_w(inst_w), .act_rd(act_rd), .wgt_rd(wgt_rd),
    .feed_zero(feed_zero), .rd_valid(rd_valid), .rd_row(rd_row),
    .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] perf_acc;

  logic [OBSW-1:0] obs;
  assign obs = {os_en, inst_w, act_rd, wgt_rd, feed_zero, rd_valid, rd_row, busy, done, err};

  // Phase boundaries of a job, in cycles after the edge that samples start.
  function automatic int job_len(input bit m, input int k);
    int exec_start;
    exec_start = 2 + (m ? 0 : COL);
    return exec_start + (m ? k + 1 : k) + (m ? ROW - 1 : ROW + COL - 1) + (m ? ROW : 0);
  endfunction

  function automatic logic [OBSW-1:0] exp_vec(input bit m, input int k, input int t);
    int p_exec, p_settle, p_read, p_done;
    logic os, ar, wr, fz, rv, bz, dn;
    logic [2*ROW-1:0] iw;
    logic [RW-1:0] rr;
    p_exec   = 2 + (m ? 0 : COL);
    p_settle = p_exec + (m ? k + 1 : k);
    p_read   = p_settle + (m ? ROW - 1 : ROW + COL - 1);
    p_done   = p_read + (m ? ROW : 0);
    os = (t >= 2 && t <= p_done) ? m : 1'b0;
    bz = (t >= 1 && t <= p_done);
    dn = (t == p_done);
    fz = (t == 1) || (m && t == p_settle - 1);
    ar = (!m && t >= 2 && t < p_settle) || (m && t >= p_exec && t < p_settle - 1);
    wr = m && t >= p_exec && t < p_settle - 1;
    rv = m && t >= p_read && t < p_done;
    rr = rv ? RW'(t - p_read) : '0;
    iw = '0;
    for (int r = 0; r < ROW; r++) begin
      int u;
      u = t - r;
      if (u >= 2 && u < p_exec)             iw[2*r +: 2] = 2'b01;
      else if (u >= p_exec && u < p_settle) iw[2*r +: 2] = 2'b10;
    end
    return {os, iw, ar, wr, fz, rv, rr, bz, dn, 1'b0};
  endfunction

  task automatic check_vec(input string name, input int t, input logic [OBSW-1:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, obs, want);
    end
  endtask

  task automatic check_perf(input string name);
    logic [31:0] want;
`ifdef MAC_SEQ_PERF_CNT_EN
    want = perf_acc;
`else
    want = 32'd0;
`endif
    checks++;
    if (perf_cycles !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, perf_cycles, want);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first idle cycle after done, so a following job starts back-to-back.
  task automatic run_job(input bit m, input int k, input int poke_t, input int abort_t,
                         output int done_t);
    int p_done;
    p_done = job_len(m, k);
    done_t = -1;
    start = 1'b1; mode = m; k_len = KBW'(k);
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); k_len = KBW'($urandom);
    for (int t = 1; t <= p_done + 1; t++) begin
      check_vec("cycle", t, exp_vec(m, k, t));
      if (done && done_t < 0) done_t = t;
      if (t == abort_t) begin
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        perf_acc = 32'd0;
        check_vec("after_reset", t + 1, '0);
        check_perf("perf_after_reset");
        return;
      end
      if (t <= p_done) begin
        start = (t == poke_t);
        if (start) begin
          mode  = 1'($urandom);
          k_len = KBW'($urandom_range(0, 255));
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    perf_acc = perf_acc + 32'(p_done);
    check_perf("perf_job");
  endtask

  task automatic err_start();
    start = 1'b1; k_len = '0; mode = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check_vec("err_pulse", 1, OBSW'(1));
    @(negedge clk);
    check_vec("err_clear", 2, '0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_vec("idle", 0, '0);
  endtask

  typedef struct {
    bit m;
    int k;
    int poke_t;
    int exp_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int d;
    tbl[0] = '{1'b1,   4,  0,  22};
    tbl[1] = '{1'b0,   4,  0,  29};
    tbl[2] = '{1'b1,   1,  0,  19};
    tbl[3] = '{1'b0,   1,  0,  26};
    tbl[4] = '{1'b1,   4,  4,  22};
    tbl[5] = '{1'b0,   4, 11,  29};
    tbl[6] = '{1'b1, 255,  0, 273};
    tbl[7] = '{1'b0, 200,  0, 225};

    reset = 1'b1; start = 1'b0; mode = 1'b0; k_len = '0;
    perf_acc = 32'd0;
    repeat (3) @(negedge clk);
    check_vec("reset_state", 0, '0);
    check_perf("perf_reset");
    reset = 1'b0;
    idle_cycle();

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].m, tbl[i].k, tbl[i].poke_t, 0, d);
      checks++;
      if (d != tbl[i].exp_done) begin
        errors++;
        $display("FAIL done_cycle vec=%0d got=%0d want=%0d", i, d, tbl[i].exp_done);
      end
    end

    err_start();
    repeat (3) idle_cycle();

    // Reset during OS readout at rd_row=3 (cycle 17), then restart cleanly.
    run_job(1'b1, 4, 0, 17, d);
    run_job(1'b1, 4, 0, 0, d);
    checks++;
    if (d != 22) begin
      errors++;
      $display("FAIL done_after_reset got=%0d want=22", d);
    end
    run_job(1'b1, 4, 0, 0, d);
    checks++;
`ifdef MAC_SEQ_PERF_CNT_EN
    if (perf_cycles !== 32'd44) begin
      errors++;
      $display("FAIL perf_two_jobs got=%0d want=44", perf_cycles);
    end
`else
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_two_jobs got=%0d want=0", perf_cycles);
    end
`endif

    for (int j = 0; j < 15; j++) begin
      int gap, k, poke;
      bit m;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) err_start();
        else idle_cycle();
      end
      m = 1'($urandom);
      k = $urandom_range(1, 40);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(2, job_len(m, k)) : 0;
      run_job(m, k, poke, 0, d);
      checks++;
      if (d != job_len(m, k)) begin
        errors++;
        $display("FAIL rand_done job=%0d got=%0d want=%0d", j, d, job_len(m, k));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
